up_bus_bridge_fsm: RTL and testbench
====================================

// Module: uP_bus_bridge_fsm
// PURPOSE
//  Parametrised successor to the fixed uP/bus interface controller. Moves a packet of IN_BYTES
//  from the uP over a 4-phase byte handshake, writes it onto the 32-bit system bus, reads
//  back RD_WORDS words, and returns OUT_BYTES to the uP. The packet/word counters are internal.
//  Adds a handshake timeout with error reporting, plus a write-only mode that skips bus readback.
//  Sits between the uP port shim (byte registers) and the 32-bit bus master datapath.
// PARAMETERS
//  IN_BYTES      8     bytes read from uP per transaction (>=1)
//  OUT_BYTES     8     bytes returned to uP per transaction (>=1)
//  RD_WORDS      2     bus words read back from slave (>=1)
//  TIMEOUT_CYC   1024  max cycles in any handshake-wait state; 0 = timeout disabled
// PORTS
//  clk             in   1   clock
//  reset           in   1   asynchronous, active-low reset
//  uP_start        in   1   uP requests transaction; held high until uP_ack/uP_error seen
//  uP_handshake_1  in   1   uP strobe (4-phase)
//  uP_soft_reset   in   1   decoded soft-reset command, valid in DECODE
//  write_only      in   1   decoded write-only command, valid in DECODE
//  bus_handshake_2 in   1   slave acknowledge (4-phase)
//  uP_handshake_2  out  1   bridge strobe to uP
//  uP_ack          out  1   transaction complete
//  uP_error        out  1   handshake timeout occurred
//  bus_handshake_1 out  1   bridge request to bus
//  read_uP_byte    out  1   1-cycle: latch uP byte into in-packet[byte_idx]
//  write_uP_byte   out  1   1-cycle: drive out-packet[byte_idx] to uP port
//  read_bus_word   out  1   1-cycle: latch bus word into out-packet word[word_idx]
//  clear_uP_packet out  1   1-cycle: clear out-packet buffer
//  byte_idx        out  $clog2(max(IN,OUT)+1)  current byte index
//  word_idx        out  $clog2(RD_WORDS+1)     current word index
//  busy            out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, byte_idx/word_idx/timer 0. Moore outputs only, all registered-state decoded.
//  IDLE -uP_start-> RUP_INIT (byte_idx<=0).
//  RUP: WAIT_H (hs1==1) -> READ (read_uP_byte) -> ACK (uP_handshake_2) -> WAIT_L (hs2 held, hs1==0)
//   -> NEXT: byte_idx==IN_BYTES-1 ? DECODE : byte_idx++, WAIT_H.
//  DECODE: soft_reset -> CLEAR (clear_uP_packet) -> WUP_INIT; else WB_REQ.
//  WB: REQ/WAIT_H (bus_handshake_1 high until hs2==1) -> WAIT_L (hs1 low, until hs2==0)
//   -> write_only ? CLEAR->WUP_INIT : RB_INIT (word_idx<=0).
//  RB: REQ/WAIT_H (hs1 high) -> READ (read_bus_word, hs1 high) -> WAIT_L (hs2==0)
//   -> NEXT: word_idx==RD_WORDS-1 ? WUP_INIT : word_idx++, REQ.
//  WUP: INIT (byte_idx<=0) -> WRITE (write_uP_byte) -> STROBE/WAIT_H (uP_handshake_2 until hs1==1)
//   -> WAIT_L (hs1==0) -> NEXT: last byte ? DONE_ACK : byte_idx++, WRITE.
//  DONE_ACK/DONE_WAIT: uP_ack high until uP_start==0 -> IDLE.
//  Timeout: timer clears on every state change; increments in each *WAIT* state; when timer reaches TIMEOUT_CYC-1
//   -> ERR: all handshake outputs 0, uP_error high until uP_start==0, then IDLE. Not checked when TIMEOUT_CYC==0.
//  uP_start dropping mid-transaction is ignored, except in DONE_WAIT/ERR.
//  Async reset mid-transaction: immediate return to IDLE; handshakes drop same edge.
//  Indices never exceed IN/OUT_BYTES-1 or RD_WORDS-1; no wrap. Strobes are exactly 1 cycle per item.
// TESTING
//  IN=4,OUT=4,RD=2: full txn, uP/bus respond in 2 cycles -> 4 read_uP_byte, 1 WB, 2 read_bus_word, 4 write_uP_byte, uP_ack.
//  soft_reset=1 at DECODE -> clear_uP_packet 1 cycle, no bus_handshake_1, 4 bytes returned, uP_ack.
//  write_only=1 -> one bus write, zero read_bus_word, clear_uP_packet pulse, uP_ack.
//  TIMEOUT_CYC=16, slave never acks -> uP_error after 16 WAIT cycles, bus_handshake_1=0; uP_start low -> IDLE.
//  Assert reset during RB word 1 -> all outputs 0 at once; next uP_start runs clean txn from byte 0.
//  TIMEOUT_CYC=0, slave ack delayed 5000 cycles -> no error, txn completes normally.

Source files
------------

// File: rtl/up_bus_bridge_fsm.sv
// uP <-> 32-bit bus bridge controller: gathers a uP packet over a 4-phase byte handshake,
// writes it to the bus, reads words back and returns a packet to the uP, with handshake timeout.
module up_bus_bridge_fsm #(
    parameter  int unsigned IN_BYTES    = 8,
    parameter  int unsigned OUT_BYTES   = 8,
    parameter  int unsigned RD_WORDS    = 2,
    parameter  int unsigned TIMEOUT_CYC = 1024,
    localparam int unsigned MAX_BYTES   = (IN_BYTES > OUT_BYTES) ? IN_BYTES : OUT_BYTES,
    localparam int unsigned BW          = $clog2(MAX_BYTES + 1),
    localparam int unsigned WW          = $clog2(RD_WORDS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          uP_start,
    input  logic          uP_handshake_1,
    input  logic          uP_soft_reset,
    input  logic          write_only,
    input  logic          bus_handshake_2,
    output logic          uP_handshake_2,
    output logic          uP_ack,
    output logic          uP_error,
    output logic          bus_handshake_1,
    output logic          read_uP_byte,
    output logic          write_uP_byte,
    output logic          read_bus_word,
    output logic          clear_uP_packet,
    output logic [BW-1:0] byte_idx,
    output logic [WW-1:0] word_idx,
    output logic          busy
);

    localparam int unsigned   TW      = $clog2(TIMEOUT_CYC + 2);
    localparam bit            TO_EN   = (TIMEOUT_CYC != 0);
    localparam logic [TW-1:0] T_LAST  = TW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
    localparam logic [BW-1:0] IN_LAST = BW'(IN_BYTES - 1);
    localparam logic [BW-1:0] OUT_LAST = BW'(OUT_BYTES - 1);
    localparam logic [WW-1:0] RD_LAST = WW'(RD_WORDS - 1);

    typedef enum logic [4:0] {
        S_IDLE,
        S_RUP_INIT,
        S_RUP_WAIT_H,
        S_RUP_READ,
        S_RUP_ACK,
        S_RUP_WAIT_L,
        S_RUP_NEXT,
        S_DECODE,
        S_CLEAR,
        S_WB_REQ,
        S_WB_WAIT_L,
        S_RB_INIT,
        S_RB_REQ,
        S_RB_READ,
        S_RB_WAIT_L,
        S_RB_NEXT,
        S_WUP_INIT,
        S_WUP_WRITE,
        S_WUP_STROBE,
        S_WUP_WAIT_L,
        S_WUP_NEXT,
        S_DONE_ACK,
        S_DONE_WAIT,
        S_ERR
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [TW-1:0] timer_q;
    logic          wr_only_q;
    logic          in_wait;
    logic          timed_out;
    logic          byte_clr;
    logic          byte_inc;
    logic          word_clr;
    logic          word_inc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            wr_only_q <= 1'b0;
            byte_idx  <= '0;
            word_idx  <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                timer_q <= '0;
            end else if (TO_EN && in_wait) begin
                timer_q <= timer_q + 1'b1;
            end
            // write_only is only valid in DECODE but is consumed after the bus write
            if (state_q == S_DECODE) begin
                wr_only_q <= write_only;
            end
            if (byte_clr) begin
                byte_idx <= '0;
            end else if (byte_inc) begin
                byte_idx <= byte_idx + 1'b1;
            end
            if (word_clr) begin
                word_idx <= '0;
            end else if (word_inc) begin
                word_idx <= word_idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        in_wait         = 1'b0;
        timed_out       = TO_EN && (timer_q == T_LAST);
        byte_clr        = 1'b0;
        byte_inc        = 1'b0;
        word_clr        = 1'b0;
        word_inc        = 1'b0;
        uP_handshake_2  = 1'b0;
        uP_ack          = 1'b0;
        uP_error        = 1'b0;
        bus_handshake_1 = 1'b0;
        read_uP_byte    = 1'b0;
        write_uP_byte   = 1'b0;
        read_bus_word   = 1'b0;
        clear_uP_packet = 1'b0;
        busy            = (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (uP_start) state_d = S_RUP_INIT;
            end
            S_RUP_INIT: begin
                byte_clr = 1'b1;
                state_d  = S_RUP_WAIT_H;
            end
            S_RUP_WAIT_H: begin
                in_wait = 1'b1;
                if (uP_handshake_1)  state_d = S_RUP_READ;
                else if (timed_out)  state_d = S_ERR;
            end
            S_RUP_READ: begin
                read_uP_byte = 1'b1;
                state_d      = S_RUP_ACK;
            end
            S_RUP_ACK: begin
                uP_handshake_2 = 1'b1;
                state_d        = S_RUP_WAIT_L;
            end
            S_RUP_WAIT_L: begin
                in_wait        = 1'b1;
                uP_handshake_2 = 1'b1;
                if (!uP_handshake_1) state_d = S_RUP_NEXT;
                else if (timed_out)  state_d = S_ERR;
            end
            S_RUP_NEXT: begin
                if (byte_idx == IN_LAST) begin
                    state_d = S_DECODE;
                end else begin
                    byte_inc = 1'b1;
                    state_d  = S_RUP_WAIT_H;
                end
            end
            S_DECODE: begin
                state_d = uP_soft_reset ? S_CLEAR : S_WB_REQ;
            end
            S_CLEAR: begin
                clear_uP_packet = 1'b1;
                state_d         = S_WUP_INIT;
            end
            S_WB_REQ: begin
                in_wait         = 1'b1;
                bus_handshake_1 = 1'b1;
                if (bus_handshake_2) state_d = S_WB_WAIT_L;
                else if (timed_out)  state_d = S_ERR;
            end
            S_WB_WAIT_L: begin
                in_wait = 1'b1;
                if (!bus_handshake_2) state_d = wr_only_q ? S_CLEAR : S_RB_INIT;
                else if (timed_out)   state_d = S_ERR;
            end
            S_RB_INIT: begin
                word_clr = 1'b1;
                state_d  = S_RB_REQ;
            end
            S_RB_REQ: begin
                in_wait         = 1'b1;
                bus_handshake_1 = 1'b1;
                if (bus_handshake_2) state_d = S_RB_READ;
                else if (timed_out)  state_d = S_ERR;
            end
            S_RB_READ: begin
                bus_handshake_1 = 1'b1;
                read_bus_word   = 1'b1;
                state_d         = S_RB_WAIT_L;
            end
            S_RB_WAIT_L: begin
                in_wait = 1'b1;
                if (!bus_handshake_2) state_d = S_RB_NEXT;
                else if (timed_out)   state_d = S_ERR;
            end
            S_RB_NEXT: begin
                if (word_idx == RD_LAST) begin
                    state_d = S_WUP_INIT;
                end else begin
                    word_inc = 1'b1;
                    state_d  = S_RB_REQ;
                end
            end
            S_WUP_INIT: begin
                byte_clr = 1'b1;
                state_d  = S_WUP_WRITE;
            end
            S_WUP_WRITE: begin
                write_uP_byte = 1'b1;
                state_d       = S_WUP_STROBE;
            end
            S_WUP_STROBE: begin
                in_wait        = 1'b1;
                uP_handshake_2 = 1'b1;
                if (uP_handshake_1) state_d = S_WUP_WAIT_L;
                else if (timed_out) state_d = S_ERR;
            end
            S_WUP_WAIT_L: begin
                in_wait = 1'b1;
                if (!uP_handshake_1) state_d = S_WUP_NEXT;
                else if (timed_out)  state_d = S_ERR;
            end
            S_WUP_NEXT: begin
                if (byte_idx == OUT_LAST) begin
                    state_d = S_DONE_ACK;
                end else begin
                    byte_inc = 1'b1;
                    state_d  = S_WUP_WRITE;
                end
            end
            S_DONE_ACK: begin
                uP_ack  = 1'b1;
                state_d = S_DONE_WAIT;
            end
            S_DONE_WAIT: begin
                uP_ack = 1'b1;
                if (!uP_start) state_d = S_IDLE;
            end
            S_ERR: begin
                uP_error = 1'b1;
                if (!uP_start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_up_bus_bridge_fsm.sv
// Bench for up_bus_bridge_fsm: directed transactions against a transaction-level event model,
// with responders for the uP and bus sides and per-cycle protocol checks.
module tb_up_bus_bridge_fsm;

    localparam int unsigned IN_B  = 4;
    localparam int unsigned OUT_B = 4;
    localparam int unsigned RD_W  = 2;
    localparam int unsigned BW    = $clog2(((IN_B > OUT_B) ? IN_B : OUT_B) + 1);
    localparam int unsigned WW    = $clog2(RD_W + 1);

    logic clk, reset, uP_start, uP_handshake_1, uP_soft_reset, write_only, bus_handshake_2;

    logic a_hs2_up, a_ack, a_err, a_bh1, a_rub, a_wub, a_rbw, a_clr, a_busy;
    logic b_hs2_up, b_ack, b_err, b_bh1, b_rub, b_wub, b_rbw, b_clr, b_busy;
    logic [BW-1:0] a_bidx, b_bidx;
    logic [WW-1:0] a_widx, b_widx;

    logic v_hs2_up, v_ack, v_err, v_bh1, v_rub, v_wub, v_rbw, v_clr, v_busy;
    logic [BW-1:0] v_bidx;
    logic [WW-1:0] v_widx;
    logic sel_b;

    int total = 0;
    int bad = 0;
    int exp_q[$];
    int up_delay = 2;
    int bus_delay = 2;
    int bus_mute = 0;
    int exp_to_cyc = 0;
    int n_rub, n_rbw, n_wub, n_clr, n_breq;

    up_bus_bridge_fsm #(.IN_BYTES(IN_B), .OUT_BYTES(OUT_B), .RD_WORDS(RD_W), .TIMEOUT_CYC(16)) dut_a (
        .clk(clk), .reset(reset), .uP_start(uP_start), .uP_handshake_1(uP_handshake_1),
        .uP_soft_reset(uP_soft_reset), .write_only(write_only), .bus_handshake_2(bus_handshake_2),
        .uP_handshake_2(a_hs2_up), .uP_ack(a_ack), .uP_error(a_err), .bus_handshake_1(a_bh1),
        .read_uP_byte(a_rub), .write_uP_byte(a_wub), .read_bus_word(a_rbw),
        .clear_uP_packet(a_clr), .byte_idx(a_bidx), .word_idx(a_widx), .busy(a_busy)
    );

    up_bus_bridge_fsm #(.IN_BYTES(IN_B), .OUT_BYTES(OUT_B), .RD_WORDS(RD_W), .TIMEOUT_CYC(0)) dut_b (
        .clk(clk), .reset(reset), .uP_start(uP_start), .uP_handshake_1(uP_handshake_1),
        .uP_soft_reset(uP_soft_reset), .write_only(write_only), .bus_handshake_2(bus_handshake_2),
        .uP_handshake_2(b_hs2_up), .uP_ack(b_ack), .uP_error(b_err), .bus_handshake_1(b_bh1),
        .read_uP_byte(b_rub), .write_uP_byte(b_wub), .read_bus_word(b_rbw),
        .clear_uP_packet(b_clr), .byte_idx(b_bidx), .word_idx(b_widx), .busy(b_busy)
    );

    // Both instances see the same inputs; responders and checks follow the selected one.
    assign v_hs2_up = sel_b ? b_hs2_up : a_hs2_up;
    assign v_ack    = sel_b ? b_ack    : a_ack;
    assign v_err    = sel_b ? b_err    : a_err;
    assign v_bh1    = sel_b ? b_bh1    : a_bh1;
    assign v_rub    = sel_b ? b_rub    : a_rub;
    assign v_wub    = sel_b ? b_wub    : a_wub;
    assign v_rbw    = sel_b ? b_rbw    : a_rbw;
    assign v_clr    = sel_b ? b_clr    : a_clr;
    assign v_busy   = sel_b ? b_busy   : a_busy;
    assign v_bidx   = sel_b ? b_bidx   : a_bidx;
    assign v_widx   = sel_b ? b_widx   : a_widx;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, got, want);
        end
    endtask

    // Event codes: 100+i uP byte read, 200 bus request, 300+w bus word read,
    // 400 packet clear, 500+i uP byte write, 600 ack, 700 error.
    task automatic load_expect(input int mode);
        exp_q.delete();
        for (int i = 0; i < int'(IN_B); i++) exp_q.push_back(100 + i);
        if (mode == 3) begin
            exp_q.push_back(200);
            exp_q.push_back(700);
        end else begin
            if (mode != 1) exp_q.push_back(200);
            if (mode == 0) begin
                for (int w = 0; w < int'(RD_W); w++) begin
                    exp_q.push_back(200);
                    exp_q.push_back(300 + w);
                end
            end
            if (mode != 0) exp_q.push_back(400);
            for (int i = 0; i < int'(OUT_B); i++) exp_q.push_back(500 + i);
            exp_q.push_back(600);
        end
    endtask

    task automatic log_event(input int ev);
        if (exp_q.size() == 0) check("event_extra", ev, 0);
        else check("event_order", ev, exp_q.pop_front());
    endtask

    initial begin : monitor
        logic p_bh1, p_ack, p_err, p_rub, p_wub, p_rbw, p_clr;
        int bh1_cyc;
        p_bh1 = 0; p_ack = 0; p_err = 0; p_rub = 0; p_wub = 0; p_rbw = 0; p_clr = 0;
        bh1_cyc = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_q.delete();
                p_bh1 = 0; p_ack = 0; p_err = 0; p_rub = 0; p_wub = 0; p_rbw = 0; p_clr = 0;
                bh1_cyc = 0;
            end else begin
                if (v_rub) begin
                    log_event(100 + int'(v_bidx)); n_rub++;
                    check("rub_1cyc", p_rub, 0);
                    check("rub_hs1_high", uP_handshake_1, 1);
                end
                if (v_bh1 && !p_bh1) begin log_event(200); n_breq++; end
                if (v_rbw) begin
                    log_event(300 + int'(v_widx)); n_rbw++;
                    check("rbw_1cyc", p_rbw, 0);
                    check("rbw_hs2_high", bus_handshake_2, 1);
                end
                if (v_clr) begin log_event(400); n_clr++; check("clr_1cyc", p_clr, 0); end
                if (v_wub) begin log_event(500 + int'(v_bidx)); n_wub++; check("wub_1cyc", p_wub, 0); end
                if (v_ack && !p_ack) log_event(600);
                if (v_err && !p_err) begin
                    log_event(700);
                    if (exp_to_cyc != 0) check("timeout_len", bh1_cyc, exp_to_cyc);
                end
                if (v_err) check("err_quiet", {v_hs2_up, v_bh1, v_ack}, 0);
                check("strobe_excl", ($countones({v_rub, v_wub, v_rbw, v_clr}) > 1), 0);
                if (v_hs2_up || v_bh1 || v_ack || v_err || v_rub || v_wub || v_rbw || v_clr)
                    check("busy_with_out", v_busy, 1);
                check("bidx_range", (int'(v_bidx) > 3), 0);
                check("widx_range", (int'(v_widx) > 1), 0);
                if (v_bh1) bh1_cyc++;
                p_bh1 = v_bh1; p_ack = v_ack; p_err = v_err; p_rub = v_rub;
                p_wub = v_wub; p_rbw = v_rbw; p_clr = v_clr;
            end
        end
    end

    initial begin : up_side
        int cnt, sent;
        logic want;
        cnt = 0; sent = 0; uP_handshake_1 = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset || !v_busy) begin
                uP_handshake_1 = 1'b0; cnt = 0; sent = 0;
            end else begin
                if (sent < int'(IN_B)) want = (uP_handshake_1 == v_hs2_up);
                else                   want = (uP_handshake_1 != v_hs2_up);
                if (want) begin
                    cnt++;
                    if (cnt >= up_delay) begin
                        if (sent < int'(IN_B) && uP_handshake_1) sent++;
                        uP_handshake_1 = !uP_handshake_1;
                        cnt = 0;
                    end
                end else begin
                    cnt = 0;
                end
            end
        end
    end

    initial begin : bus_side
        int cnt;
        cnt = 0; bus_handshake_2 = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset || bus_mute != 0) begin
                bus_handshake_2 = 1'b0; cnt = 0;
            end else if (v_bh1 != bus_handshake_2) begin
                cnt++;
                if (cnt >= (v_bh1 ? bus_delay : 2)) begin
                    bus_handshake_2 = v_bh1; cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic clear_counts();
        n_rub = 0; n_rbw = 0; n_wub = 0; n_clr = 0; n_breq = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0; uP_start = 1'b0; uP_soft_reset = 1'b0; write_only = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_txn(input int mode, input int limit, output int cyc);
        clear_counts();
        load_expect(mode);
        uP_soft_reset = (mode == 1);
        write_only    = (mode == 2);
        uP_start      = 1'b1;
        cyc = 0;
        while (!(v_ack || v_err) && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (v_bh1) write_only = 1'b0;
            if (v_clr) uP_soft_reset = 1'b0;
        end
        check("txn_end", (v_ack || v_err), 1);
        repeat (3) @(negedge clk);
        check("end_hold", (v_ack || v_err), 1);
        uP_start = 1'b0;
        for (int i = 0; i < 10 && v_busy; i++) @(negedge clk);
        check("back_idle", v_busy, 0);
        check("idle_flags", {v_ack, v_err}, 0);
        check("events_left", exp_q.size(), 0);
        uP_soft_reset = 1'b0;
        write_only = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cyc;
        reset = 1'b0; uP_start = 1'b0; uP_soft_reset = 1'b0; write_only = 1'b0; sel_b = 1'b0;
        clear_counts();
        repeat (2) @(negedge clk);
        check("rst_outputs", {v_hs2_up, v_ack, v_err, v_bh1, v_rub, v_wub, v_rbw, v_clr, v_busy}, 0);
        check("rst_bidx", v_bidx, 0);
        check("rst_widx", v_widx, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_start", v_busy, 0);

        run_txn(0, 500, cyc);
        check("norm_n_rub", n_rub, 4);
        check("norm_n_breq", n_breq, 3);
        check("norm_n_rbw", n_rbw, 2);
        check("norm_n_wub", n_wub, 4);
        check("norm_n_clr", n_clr, 0);

        do_reset();
        run_txn(1, 500, cyc);
        check("soft_n_breq", n_breq, 0);
        check("soft_n_clr", n_clr, 1);
        check("soft_n_wub", n_wub, 4);

        do_reset();
        run_txn(2, 500, cyc);
        check("wo_n_breq", n_breq, 1);
        check("wo_n_rbw", n_rbw, 0);
        check("wo_n_clr", n_clr, 1);
        check("wo_n_wub", n_wub, 4);

        do_reset();
        bus_mute = 1; exp_to_cyc = 16;
        run_txn(3, 200, cyc);
        check("to_n_breq", n_breq, 1);
        check("to_n_wub", n_wub, 0);
        bus_mute = 0; exp_to_cyc = 0;

        do_reset();
        clear_counts();
        load_expect(0);
        uP_start = 1'b1;
        cyc = 0;
        while (!(v_bh1 && v_widx == 1) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_rb_word1", (cyc < 500), 1);
        #1 reset = 1'b0;
        #1;
        check("async_outputs", {v_hs2_up, v_ack, v_err, v_bh1, v_rub, v_wub, v_rbw, v_clr, v_busy}, 0);
        check("async_bidx", v_bidx, 0);
        check("async_widx", v_widx, 0);
        check("abort_n_rbw", n_rbw, 1);
        uP_start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_txn(0, 500, cyc);
        check("rerun_n_rub", n_rub, 4);
        check("rerun_n_wub", n_wub, 4);

        do_reset();
        sel_b = 1'b1; bus_delay = 5000;
        run_txn(0, 20000, cyc);
        check("slow_cyc_min", (cyc > 5000), 1);
        check("slow_n_rbw", n_rbw, 2);
        bus_delay = 2;
        do_reset();
        sel_b = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
